// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types, defines and helpers for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WB_ARB_DEFINES_SVH
`define WB_ARB_DEFINES_SVH
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`define WB_QUEUE_DEPTH 4
`define REG_X0 5'd0
`endif

package wb_arb_pkg;

    typedef logic [`RegAddrBus] reg_addr_t;
    typedef logic [`RegBus]     reg_data_t;

    // Which source feeds the output register this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_HEAD = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

    // One-hot register mask; x0 never appears as busy.
    function automatic reg_data_t reg_onehot(input reg_addr_t a);
        reg_data_t v;
        v = '0;
        if (a != `REG_X0) v[a] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_if
// Description : Result-source and register-file bus of the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

interface wb_arb_if #(
    parameter int CW = 3
);
    import wb_arb_pkg::*;

    logic          ex_we_i;
    reg_addr_t     ex_waddr_i;
    reg_data_t     ex_wdata_i;
    logic          lsu_vld_i;
    logic          lsu_rdy_o;
    reg_addr_t     lsu_waddr_i;
    reg_data_t     lsu_wdata_i;
    logic          div_vld_i;
    logic          div_rdy_o;
    reg_addr_t     div_waddr_i;
    reg_data_t     div_wdata_i;
    logic          we_o;
    reg_addr_t     waddr_o;
    reg_data_t     wdata_o;
    reg_data_t     busy_o;
    logic [CW-1:0] cnt_o;

    // Arbiter side.
    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  lsu_vld_i, lsu_waddr_i, lsu_wdata_i,
        input  div_vld_i, div_waddr_i, div_wdata_i,
        output lsu_rdy_o, div_rdy_o,
        output we_o, waddr_o, wdata_o, busy_o, cnt_o
    );

    // Producer / register-file side.
    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output lsu_vld_i, lsu_waddr_i, lsu_wdata_i,
        output div_vld_i, div_waddr_i, div_wdata_i,
        input  lsu_rdy_o, div_rdy_o,
        input  we_o, waddr_o, wdata_o, busy_o, cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : In-order circular buffer of slow write-back results with
//               per-entry valid bits, kill-by-address and busy mask.
// Revision    : 1.0 - initial release
// ============================================================================

module wb_queue
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = `WB_QUEUE_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire logic      i_push,
    input  wire reg_addr_t i_push_addr,
    input  wire reg_data_t i_push_data,
    input  wire logic      i_pop,
    input  wire logic      i_kill,
    input  wire reg_addr_t i_kill_addr,
    output logic           o_head_vld,
    output reg_addr_t      o_head_addr,
    output reg_data_t      o_head_data,
    output logic [CW-1:0]  o_cnt,
    output reg_data_t      o_busy
);

    localparam int c_PW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_vld;
    reg_addr_t        r_addr [DEPTH];
    reg_data_t        r_data [DEPTH];
    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [CW-1:0]    r_cnt;

    logic [DEPTH-1:0] w_kill;
    logic [DEPTH-1:0] w_vld_nxt;
    reg_data_t        w_ent_busy [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_kill[g]     = i_kill & r_vld[g] & (r_addr[g] == i_kill_addr);
        assign w_ent_busy[g] = r_vld[g] ? reg_onehot(r_addr[g]) : '0;
    end

    // Next valid bits: kill first, then pop clears head, push sets tail.
    always_comb begin
        w_vld_nxt = r_vld & ~w_kill;
        if (i_pop)  w_vld_nxt[r_head] = 1'b0;
        if (i_push) w_vld_nxt[r_tail] = 1'b1;
    end

    // Control state: valid bits, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (i_pop)  r_head <= r_head + c_PW'(1);
            if (i_push) r_tail <= r_tail + c_PW'(1);
            if (i_push && !i_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!i_push && i_pop) r_cnt <= r_cnt - CW'(1);
        end
    end

    // Payload storage; guarded by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    // OR of the one-hot masks of all live entries.
    always_comb begin
        o_busy = '0;
        for (int i = 0; i < DEPTH; i++) o_busy = o_busy | w_ent_busy[i];
    end

    assign o_head_vld  = r_vld[r_head];
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_cnt       = r_cnt;

endmodule

`default_nettype wire

// File: rtl/wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb
// Description : Write-back arbiter merging execute, LSU and divider results
//               onto the register file's single write port.
// Revision    : 1.0 - initial release
// ============================================================================

module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = `WB_QUEUE_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    wb_arb_if.slave   bus
);

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic          w_space;
    logic          w_lsu_acc;
    logic          w_div_acc;
    logic          w_slow_live;
    reg_addr_t     w_slow_addr;
    reg_data_t     w_slow_data;
    logic          w_ex_take;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_head_vld;
    reg_addr_t     w_head_addr;
    reg_data_t     w_head_data;
    logic [CW-1:0] w_cnt;
    reg_data_t     w_q_busy;
    wb_src_e       w_src;
    reg_addr_t     w_sel_addr;
    reg_data_t     w_sel_data;

    logic          r_we;
    reg_addr_t     r_waddr;
    reg_data_t     r_wdata;

    // Ready depends only on occupancy and the LSU valid (LSU wins over divider).
    assign w_space       = (w_cnt < c_FULL);
    assign bus.lsu_rdy_o = w_space;
    assign bus.div_rdy_o = w_space & ~bus.lsu_vld_i;

    assign w_lsu_acc   = bus.lsu_vld_i & w_space;
    assign w_div_acc   = bus.div_vld_i & w_space & ~bus.lsu_vld_i;
    assign w_slow_addr = w_lsu_acc ? bus.lsu_waddr_i : bus.div_waddr_i;
    assign w_slow_data = w_lsu_acc ? bus.lsu_wdata_i : bus.div_wdata_i;
    // x0 results are accepted by the handshake but otherwise vanish.
    assign w_slow_live = (w_lsu_acc | w_div_acc) & (w_slow_addr != `REG_X0);

    assign w_ex_take = bus.ex_we_i & (bus.ex_waddr_i != `REG_X0);
    // An empty queue has no valid head, so bypass never skips over queued work.
    assign w_bypass  = w_slow_live & (w_cnt == '0) & ~w_ex_take;
    // A slow result to the same register as this cycle's ex write is stale.
    assign w_push    = w_slow_live & ~w_bypass &
                       ~(w_ex_take & (w_slow_addr == bus.ex_waddr_i));
    // Killed heads drain even while ex owns the port.
    assign w_pop     = (w_cnt != '0) & (~w_head_vld | ~w_ex_take);

    wb_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (w_slow_addr),
        .i_push_data (w_slow_data),
        .i_pop       (w_pop),
        .i_kill      (w_ex_take),
        .i_kill_addr (bus.ex_waddr_i),
        .o_head_vld  (w_head_vld),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_cnt       (w_cnt),
        .o_busy      (w_q_busy)
    );

    // Priority select: execute, then queue head, then bypassed slow result.
    always_comb begin
        w_src      = SRC_NONE;
        w_sel_addr = '0;
        w_sel_data = '0;
        if (w_ex_take) begin
            w_src      = SRC_EX;
            w_sel_addr = bus.ex_waddr_i;
            w_sel_data = bus.ex_wdata_i;
        end else if (w_head_vld) begin
            w_src      = SRC_HEAD;
            w_sel_addr = w_head_addr;
            w_sel_data = w_head_data;
        end else if (w_bypass) begin
            w_src      = SRC_BYP;
            w_sel_addr = w_slow_addr;
            w_sel_data = w_slow_data;
        end
    end

    // Output register; address/data hold their last value when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= (w_src != SRC_NONE);
            if (w_src != SRC_NONE) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign bus.we_o    = r_we;
    assign bus.waddr_o = r_waddr;
    assign bus.wdata_o = r_wdata;
    assign bus.cnt_o   = w_cnt;
    assign bus.busy_o  = w_q_busy | (r_we ? reg_onehot(r_waddr) : '0);

endmodule

`default_nettype wire

// File: tb/tb_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arb
// Description : Self-checking bench for wb_arb: per-cycle vector table plus a
//               write scoreboard fed as stimulus is applied.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_wb_arb;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arb_if #(.CW(CW)) bus ();

    wb_arb #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          rst;
        logic          ex_we;
        logic [4:0]    ex_a;
        logic [31:0]   ex_d;
        logic          l_v;
        logic [4:0]    l_a;
        logic [31:0]   l_d;
        logic          d_v;
        logic [4:0]    d_a;
        logic [31:0]   d_d;
        logic          e_lrdy;
        logic          e_drdy;
        logic          e_we;
        logic [4:0]    e_a;
        logic [31:0]   e_d;
        logic [CW-1:0] e_cnt;
        logic [31:0]   e_busy;
    } vec_t;

    vec_t        vecs [$];
    logic [36:0] sb   [$];
    logic [31:0] rf   [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst,
                       input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd,
                       input logic lrdy, input logic drdy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [CW-1:0] cnt, input logic [31:0] busy);
        vec_t v;
        v.rst = rst; v.ex_we = ew; v.ex_a = ea; v.ex_d = ed;
        v.l_v = lv; v.l_a = la; v.l_d = ld;
        v.d_v = dv; v.d_a = da; v.d_d = dd;
        v.e_lrdy = lrdy; v.e_drdy = drdy;
        v.e_we = we; v.e_a = wa; v.e_d = wd;
        v.e_cnt = cnt; v.e_busy = busy;
        vecs.push_back(v);
    endtask

    // Write monitor: every register-file write must match the oldest expectation.
    initial begin : mon
        logic [36:0] e;
        for (int r = 0; r < 32; r++) rf[r] = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.we_o === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual=x%0d/%h required=no write",
                             bus.waddr_o, bus.wdata_o);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", {27'd0, bus.waddr_o}, {27'd0, e[36:32]});
                    chk("wr_data", bus.wdata_o, e[31:0]);
                end
                rf[bus.waddr_o] = bus.wdata_o;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t v;
        bus.ex_we_i = 1'b0; bus.ex_waddr_i = 5'd0; bus.ex_wdata_i = 32'h0;
        bus.lsu_vld_i = 1'b0; bus.lsu_waddr_i = 5'd0; bus.lsu_wdata_i = 32'h0;
        bus.div_vld_i = 1'b0; bus.div_waddr_i = 5'd0; bus.div_wdata_i = 32'h0;

        //   rst  ex(we,a,d)              lsu(v,a,d)               div(v,a,d)               lrdy drdy  out(we,a,d)              cnt   busy
        // idle and single LSU bypass
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b1,5'd5,32'h1234,      1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd5,32'h1234,      3'd0, 32'h20);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        // backpressure: ex owns the port while LSU fills the queue
        add(1'b0, 1'b1,5'd1,32'h101,    1'b1,5'd2,32'h202,       1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h101,       3'd1, 32'h6);
        add(1'b0, 1'b1,5'd1,32'h102,    1'b1,5'd3,32'h203,       1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h102,       3'd2, 32'hE);
        add(1'b0, 1'b1,5'd1,32'h103,    1'b1,5'd4,32'h204,       1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h103,       3'd3, 32'h1E);
        add(1'b0, 1'b1,5'd1,32'h104,    1'b1,5'd5,32'h205,       1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h104,       3'd4, 32'h3E);
        add(1'b0, 1'b1,5'd1,32'h105,    1'b1,5'd6,32'h206,       1'b0,5'd0,32'h0,         1'b0,1'b0, 1'b1,5'd1,32'h105,       3'd4, 32'h3E);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b1,5'd6,32'h206,       1'b0,5'd0,32'h0,         1'b0,1'b0, 1'b1,5'd2,32'h202,       3'd3, 32'h3C);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b1,5'd6,32'h206,       1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd3,32'h203,       3'd3, 32'h78);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd4,32'h204,       3'd2, 32'h70);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd5,32'h205,       3'd1, 32'h60);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd6,32'h206,       3'd0, 32'h40);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        // all three sources at once; divider held until LSU goes idle
        add(1'b0, 1'b1,5'd7,32'hA,      1'b1,5'd8,32'hB,         1'b1,5'd9,32'hC,         1'b1,1'b0, 1'b1,5'd7,32'hA,         3'd1, 32'h180);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b1,5'd9,32'hC,         1'b1,1'b1, 1'b1,5'd8,32'hB,         3'd1, 32'h300);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd9,32'hC,         3'd0, 32'h200);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        // WAW kill: queued x10 superseded by a younger ex write
        add(1'b0, 1'b1,5'd11,32'h1,     1'b0,5'd0,32'h0,         1'b1,5'd10,32'h55,       1'b1,1'b1, 1'b1,5'd11,32'h1,        3'd1, 32'hC00);
        add(1'b0, 1'b1,5'd10,32'h99,    1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd10,32'h99,       3'd1, 32'h400);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        // same-cycle drop of a slow result to the ex destination
        add(1'b0, 1'b1,5'd20,32'hA0,    1'b0,5'd0,32'h0,         1'b1,5'd20,32'hB0,       1'b1,1'b1, 1'b1,5'd20,32'hA0,       3'd0, 32'h100000);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        // x0 handling
        add(1'b0, 1'b0,5'd0,32'h0,      1'b1,5'd0,32'hDEAD,      1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b1,5'd0,32'h77,     1'b1,5'd3,32'h33,        1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd3,32'h33,        3'd0, 32'h8);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b1,5'd15,32'hF,        1'b1,1'b1, 1'b1,5'd15,32'hF,        3'd0, 32'h8000);
        // fill to three entries, then reset mid-operation
        add(1'b0, 1'b1,5'd1,32'h1,      1'b1,5'd12,32'hC,        1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h1,         3'd1, 32'h1002);
        add(1'b0, 1'b1,5'd1,32'h2,      1'b1,5'd13,32'hD,        1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h2,         3'd2, 32'h3002);
        add(1'b0, 1'b1,5'd1,32'h3,      1'b1,5'd14,32'hE,        1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd1,32'h3,         3'd3, 32'h7002);
        add(1'b1, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);
        // last write, then idle so the held address/data can be inspected
        add(1'b0, 1'b0,5'd0,32'h0,      1'b1,5'd17,32'hABC,      1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b1,5'd17,32'hABC,      3'd0, 32'h20000);
        add(1'b0, 1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,         1'b0,5'd0,32'h0,         1'b1,1'b0, 1'b0,5'd0,32'h0,         3'd0, 32'h0);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_we",      {31'd0, bus.we_o},      32'd0);
        chk("rst_cnt",     {29'd0, bus.cnt_o},     32'd0);
        chk("rst_busy",    bus.busy_o,             32'd0);
        chk("rst_lsu_rdy", {31'd0, bus.lsu_rdy_o}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst_n           = ~v.rst;
            bus.ex_we_i     = v.ex_we; bus.ex_waddr_i  = v.ex_a; bus.ex_wdata_i  = v.ex_d;
            bus.lsu_vld_i   = v.l_v;   bus.lsu_waddr_i = v.l_a;  bus.lsu_wdata_i = v.l_d;
            bus.div_vld_i   = v.d_v;   bus.div_waddr_i = v.d_a;  bus.div_wdata_i = v.d_d;
            if (v.e_we) sb.push_back({v.e_a, v.e_d});
            #1;
            chk($sformatf("v%0d_lsu_rdy", i), {31'd0, bus.lsu_rdy_o}, {31'd0, v.e_lrdy});
            if (v.d_v)
                chk($sformatf("v%0d_div_rdy", i), {31'd0, bus.div_rdy_o}, {31'd0, v.e_drdy});
            @(negedge clk);
            #2;
            chk($sformatf("v%0d_we", i),      {31'd0, bus.we_o},  {31'd0, v.e_we});
            chk($sformatf("v%0d_cnt", i),     {29'd0, bus.cnt_o}, {29'd0, v.e_cnt});
            chk($sformatf("v%0d_busy", i),    bus.busy_o,         v.e_busy);
            chk($sformatf("v%0d_sb_done", i), sb.size(),          32'd0);
        end

        bus.ex_we_i = 1'b0; bus.lsu_vld_i = 1'b0; bus.div_vld_i = 1'b0;
        chk("hold_waddr", {27'd0, bus.waddr_o}, 32'd17);
        chk("hold_wdata", bus.wdata_o,          32'hABC);
        chk("rf_x10",     rf[10],               32'h99);
        chk("rf_x0",      rf[0],                32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
